sd_spi_card_resp: RTL and testbench

Synthesizable SD-card SPI-mode responder: the card-side end of the SD SPI init link. It receives 48-bit command frames on `sd_mosi`, returns R1/R7 responses on `sd_miso`, and tracks the idle → ready init sequence (CMD0, CMD8, CMD55, ACMD41). It sits in the RISCV_SD_Test FPGA build and benches in place of a physical card, so the SD init/read host logic can be exercised without hardware. The SPI pins are asynchronous to `clk_ref` and are oversampled.

---
 rtl/sd_spi_card_resp_if.sv | 21 ++
 rtl/sd_spi_card_resp.sv | 204 ++++++++++++++++++++
 tb/tb_sd_spi_card_resp.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_card_resp_if.sv
// SD SPI-mode pin bundle plus the card-side command status outputs.
// master = host side (drives the SPI clock, chip select and MOSI), slave = card side.
interface sd_spi_card_resp_if;
    logic       sd_clk;
    logic       sd_cs;
    logic       sd_mosi;
    logic       sd_miso;
    logic       card_ready;
    logic       cmd_valid;
    logic [5:0] cmd_index;

    modport master (
        output sd_clk, sd_cs, sd_mosi,
        input  sd_miso, card_ready, cmd_valid, cmd_index
    );

    modport slave (
        input  sd_clk, sd_cs, sd_mosi,
        output sd_miso, card_ready, cmd_valid, cmd_index
    );
endinterface

// File: rtl/sd_spi_card_resp.sv
// SD SPI-mode card model: oversampled frame capture, R1/R7 responses, idle->ready init tracking.
// Latency: cmd_valid 3 clk_ref after the end-bit rise, miso 3 clk_ref after each fall; no backpressure.
module sd_spi_card_resp #(
    parameter int NCR_BYTES   = 1,
    parameter int ACMD41_BUSY = 2
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    sd_spi_card_resp_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_NCR, ST_RESP} state_t;

    localparam logic [5:0] NCR_LAST = 6'(NCR_BYTES * 8 - 1);
    localparam logic [2:0] BUSY_N   = 3'(ACMD41_BUSY);

    logic        r_clk_s1, r_clk_s2, r_clk_d;
    logic        r_cs_s1, r_cs_s2;
    logic        r_mosi_s1, r_mosi_s2;
    state_t      r_state, w_state_nxt;
    logic [45:0] r_shift;
    logic [5:0]  r_bitcnt;
    logic [5:0]  r_cnt;
    logic [39:0] r_resp;
    logic [5:0]  r_resp_len;
    logic        r_miso;
    logic        r_cmd_valid;
    logic [5:0]  r_cmd_index;
    logic        r_in_idle, r_app_cmd, r_card_ready;
    logic [2:0]  r_acnt;

    logic        w_rise, w_fall;
    logic        w_start, w_shift, w_capture, w_ncr_tick, w_resp_tick, w_resp_done;
    logic [5:0]  w_idx;
    logic [7:0]  w_crc;
    logic [11:0] w_arg_lo;
    logic [7:0]  w_r1;
    logic        w_in_idle_nxt, w_app_nxt, w_ready_nxt;
    logic [2:0]  w_acnt_nxt;
    logic [39:0] w_resp_nxt;
    logic [5:0]  w_len_nxt;

    assign w_rise = r_clk_s2 & ~r_clk_d;
    assign w_fall = ~r_clk_s2 & r_clk_d;

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_clk_s1  <= 1'b0;
            r_clk_s2  <= 1'b0;
            r_clk_d   <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_mosi_s1 <= 1'b1;
            r_mosi_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= bus.sd_clk;
            r_clk_s2  <= r_clk_s1;
            r_clk_d   <= r_clk_s2;
            r_cs_s1   <= bus.sd_cs;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= bus.sd_mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        w_ncr_tick  = 1'b0;
        w_resp_tick = 1'b0;
        w_resp_done = 1'b0;
        if (r_cs_s2) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_rise && !r_mosi_s2) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_CMD;
                end
                ST_CMD: if (w_rise) begin
                    if (r_bitcnt == 6'd47) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_NCR;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
                ST_NCR: if (w_fall) begin
                    w_ncr_tick = 1'b1;
                    if (r_cnt == NCR_LAST) w_state_nxt = ST_RESP;
                end
                ST_RESP: if (w_fall) begin
                    if (r_cnt == r_resp_len) begin
                        w_resp_done = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_resp_tick = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // At capture, frame bit k (k>=1) sits in r_shift[k-1]; bit 0 is the live MOSI sample.
    assign w_idx    = r_shift[44:39];
    assign w_arg_lo = r_shift[18:7];
    assign w_crc    = {r_shift[6:0], r_mosi_s2};
    assign w_r1     = {7'b0, r_in_idle};

    always_comb begin
        w_in_idle_nxt = r_in_idle;
        w_app_nxt     = 1'b0;
        w_ready_nxt   = r_card_ready;
        w_acnt_nxt    = r_acnt;
        w_resp_nxt    = {w_r1 | 8'h04, 32'h0};
        w_len_nxt     = 6'd8;
        if (!r_shift[45] || !r_mosi_s2) begin
            w_resp_nxt = {w_r1 | 8'h04, 32'h0};
        end else if (w_idx == 6'd0) begin
            if (w_crc == 8'h95) begin
                w_in_idle_nxt = 1'b1;
                w_acnt_nxt    = 3'd0;
                w_ready_nxt   = 1'b0;
                w_resp_nxt    = {8'h01, 32'h0};
            end else begin
                w_resp_nxt = {w_r1 | 8'h08, 32'h0};
            end
        end else if (w_idx == 6'd8) begin
            if (w_crc == 8'h87) begin
                w_resp_nxt = {w_r1, 16'h0000, 4'h0, w_arg_lo};
                w_len_nxt  = 6'd40;
            end else begin
                w_resp_nxt = {w_r1 | 8'h08, 32'h0};
            end
        end else if (w_idx == 6'd55) begin
            w_app_nxt  = 1'b1;
            w_resp_nxt = {w_r1, 32'h0};
        end else if (w_idx == 6'd41 && r_app_cmd) begin
            if (r_acnt < BUSY_N) begin
                w_acnt_nxt = r_acnt + 3'd1;
                w_resp_nxt = {8'h01, 32'h0};
            end else begin
                w_in_idle_nxt = 1'b0;
                w_ready_nxt   = 1'b1;
                w_resp_nxt    = 40'h0;
            end
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_cnt        <= '0;
            r_resp       <= '0;
            r_resp_len   <= 6'd8;
            r_miso       <= 1'b1;
            r_cmd_valid  <= 1'b0;
            r_cmd_index  <= '0;
            r_in_idle    <= 1'b1;
            r_app_cmd    <= 1'b0;
            r_card_ready <= 1'b0;
            r_acnt       <= '0;
        end else begin
            r_cmd_valid <= w_capture;
            if (w_start) begin
                r_shift  <= '0;
                r_bitcnt <= 6'd1;
            end else if (w_shift) begin
                r_shift  <= {r_shift[44:0], r_mosi_s2};
                r_bitcnt <= r_bitcnt + 6'd1;
            end
            if (w_capture) begin
                r_cmd_index  <= w_idx;
                r_in_idle    <= w_in_idle_nxt;
                r_app_cmd    <= w_app_nxt;
                r_card_ready <= w_ready_nxt;
                r_acnt       <= w_acnt_nxt;
                r_resp       <= w_resp_nxt;
                r_resp_len   <= w_len_nxt;
                r_cnt        <= '0;
            end else if (w_ncr_tick) begin
                r_cnt <= (r_cnt == NCR_LAST) ? 6'd0 : r_cnt + 6'd1;
            end else if (w_resp_tick) begin
                r_cnt  <= r_cnt + 6'd1;
                r_resp <= {r_resp[38:0], 1'b0};
            end
            if (r_cs_s2 || w_ncr_tick || w_resp_done) r_miso <= 1'b1;
            else if (w_resp_tick)                     r_miso <= r_resp[39];
        end
    end

    assign bus.sd_miso    = r_miso;
    assign bus.card_ready = r_card_ready;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_index  = r_cmd_index;
endmodule

// File: tb/tb_sd_spi_card_resp.sv
// Drives SPI command frames into the card model and checks responses against a command-level card model.
module tb_sd_spi_card_resp;
    localparam int NCR  = 1;
    localparam int BUSY = 2;
    localparam int HALF = 5;

    logic clk_ref = 1'b0;
    logic rst_n;
    always #5 clk_ref = ~clk_ref;

    sd_spi_card_resp_if bus();

    sd_spi_card_resp #(.NCR_BYTES(NCR), .ACMD41_BUSY(BUSY)) dut (
        .clk_ref (clk_ref),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;

    bit m_in_idle = 1'b1;
    bit m_app     = 1'b0;
    bit m_ready   = 1'b0;
    int m_acnt    = 0;

    always @(posedge clk_ref) if (bus.cmd_valid === 1'b1) n_valid++;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_idle = 1'b1;
        m_app     = 1'b0;
        m_ready   = 1'b0;
        m_acnt    = 0;
    endtask

    // Command-level card behaviour: returns the response right-aligned in r with its bit length.
    task automatic model_cmd(input logic [47:0] f, output logic [39:0] r, output int len);
        int   idx;
        bit   well_formed;
        logic [7:0] r1;
        idx         = int'(f[45:40]);
        well_formed = (f[46] == 1'b1) && (f[0] == 1'b1);
        r1          = m_in_idle ? 8'h01 : 8'h00;
        len         = 8;
        r           = {32'h0, r1 | 8'h04};
        if (well_formed) begin
            case (idx)
                0: if (f[7:0] == 8'h95) begin
                       model_reset();
                       r = 40'h01;
                   end else r = {32'h0, r1 | 8'h08};
                8: if (f[7:0] == 8'h87) begin
                       r   = {r1, 16'h0000, 4'h0, f[19:8]};
                       len = 40;
                   end else r = {32'h0, r1 | 8'h08};
                55: r = {32'h0, r1};
                41: if (m_app) begin
                        if (m_acnt < BUSY) begin
                            m_acnt++;
                            r = 40'h01;
                        end else begin
                            m_in_idle = 1'b0;
                            m_ready   = 1'b1;
                            r         = 40'h00;
                        end
                    end
                default: r = {32'h0, r1 | 8'h04};
            endcase
        end
        m_app = well_formed && (idx == 55);
    endtask

    task automatic send_frame(input string tag, input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            bus.sd_mosi = f[i];
            repeat (HALF) @(negedge clk_ref);
            bus.sd_clk = 1'b1;
            if (i == 0) begin
                repeat (2) @(negedge clk_ref);
                chk({tag, "_valid_early"}, bus.cmd_valid, 1'b0);
                @(negedge clk_ref);
                chk({tag, "_valid"}, bus.cmd_valid, 1'b1);
                chk({tag, "_index"}, bus.cmd_index, f[45:40]);
                chk({tag, "_ready"}, bus.card_ready, m_ready);
                @(negedge clk_ref);
                chk({tag, "_valid_pulse"}, bus.cmd_valid, 1'b0);
                repeat (HALF - 4) @(negedge clk_ref);
            end else begin
                repeat (HALF) @(negedge clk_ref);
            end
            bus.sd_clk = 1'b0;
        end
        bus.sd_mosi = 1'b1;
    endtask

    task automatic read_bits(input int n, output logic [127:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clk_ref);
            got = {got[126:0], bus.sd_miso};
            bus.sd_clk = 1'b1;
            repeat (HALF) @(negedge clk_ref);
            bus.sd_clk = 1'b0;
        end
    endtask

    task automatic do_cmd(input string tag, input logic [47:0] f);
        logic [39:0]  r;
        logic [127:0] got;
        logic [127:0] e;
        int           len;
        int           n;
        bit           b;
        model_cmd(f, r, len);
        send_frame(tag, f);
        n = 8 * NCR + len + 8;
        read_bits(n, got);
        e = '0;
        for (int i = 0; i < n; i++) begin
            b = 1'b1;
            if (i >= 8 * NCR && i < 8 * NCR + len) b = r[len - 1 - (i - 8 * NCR)];
            e = {e[126:0], b};
        end
        chk({tag, "_resp"}, got, e);
    endtask

    task automatic acmd41_pairs(input string tag, input int pairs);
        for (int p = 0; p < pairs; p++) begin
            do_cmd({tag, "_cmd55"}, 48'h77_0000_0000_65);
            do_cmd({tag, "_acmd41"}, 48'h69_4000_0000_77);
        end
    endtask

    logic [47:0]  frame;
    logic [127:0] junk;
    logic [39:0]  rtmp;
    int           ltmp;
    int           v0;
    int           sel;
    logic [5:0]   ridx;
    logic [7:0]   rcrc;

    initial begin
        bus.sd_clk  = 1'b0;
        bus.sd_cs   = 1'b1;
        bus.sd_mosi = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk_ref);
        chk("rst_miso", bus.sd_miso, 1'b1);
        chk("rst_ready", bus.card_ready, 1'b0);
        chk("rst_valid", bus.cmd_valid, 1'b0);
        chk("rst_index", bus.cmd_index, 6'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_ref);
        bus.sd_cs = 1'b0;
        repeat (4) @(negedge clk_ref);

        do_cmd("cmd0", 48'h40_0000_0000_95);
        do_cmd("cmd8", 48'h48_0000_01AA_87);
        do_cmd("cmd0_badcrc", 48'h40_0000_0000_FF);
        do_cmd("cmd41_noapp", 48'h69_4000_0000_77);
        do_cmd("bit46_zero", 48'h00_0000_0000_95);
        acmd41_pairs("init", 3);
        chk("init_ready", bus.card_ready, 1'b1);
        do_cmd("cmd55_ready", 48'h77_0000_0000_65);

        // Chip select raised after 20 command bits: frame must vanish.
        v0    = n_valid;
        frame = 48'h40_0000_0000_95;
        for (int i = 47; i > 27; i--) begin
            bus.sd_mosi = frame[i];
            repeat (HALF) @(negedge clk_ref);
            bus.sd_clk = 1'b1;
            repeat (HALF) @(negedge clk_ref);
            bus.sd_clk = 1'b0;
        end
        bus.sd_mosi = 1'b1;
        bus.sd_cs   = 1'b1;
        repeat (8) @(negedge clk_ref);
        chk("abort_cmd_novalid", 128'(n_valid), 128'(v0));
        chk("abort_cmd_miso", bus.sd_miso, 1'b1);
        chk("abort_cmd_ready", bus.card_ready, 1'b1);
        bus.sd_cs = 1'b0;
        repeat (4) @(negedge clk_ref);
        do_cmd("cmd0_after_abort", 48'h40_0000_0000_95);

        // Chip select raised while the R7 is on the wire.
        frame = 48'h48_0000_01AA_87;
        model_cmd(frame, rtmp, ltmp);
        send_frame("cmd8_abort", frame);
        read_bits(8 * NCR + 3, junk);
        repeat (4) @(negedge clk_ref);
        chk("abort_resp_miso_low", bus.sd_miso, 1'b0);
        bus.sd_cs = 1'b1;
        repeat (3) @(negedge clk_ref);
        chk("abort_resp_miso_high", bus.sd_miso, 1'b1);
        bus.sd_cs = 1'b0;
        repeat (4) @(negedge clk_ref);
        do_cmd("cmd8_after_abort", 48'h48_0000_02C3_87);

        // Reset in the middle of a response once the card is ready.
        acmd41_pairs("reinit", 3);
        chk("reinit_ready", bus.card_ready, 1'b1);
        frame = 48'h77_0000_0000_65;
        model_cmd(frame, rtmp, ltmp);
        send_frame("cmd55_rst", frame);
        read_bits(8 * NCR + 2, junk);
        rst_n = 1'b0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_miso", bus.sd_miso, 1'b1);
        chk("midrst_ready", bus.card_ready, 1'b0);
        chk("midrst_valid", bus.cmd_valid, 1'b0);
        chk("midrst_index", bus.cmd_index, 6'd0);
        repeat (4) @(negedge clk_ref);
        do_cmd("cmd41_after_rst", 48'h69_4000_0000_77);

        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    ridx = 6'd0;
                2, 3:    ridx = 6'd8;
                4, 5:    ridx = 6'd55;
                6, 7:    ridx = 6'd41;
                default: ridx = 6'($urandom_range(0, 63));
            endcase
            rcrc = 8'($urandom) | 8'h01;
            if (ridx == 6'd0 && $urandom_range(0, 3) != 0) rcrc = 8'h95;
            if (ridx == 6'd8 && $urandom_range(0, 3) != 0) rcrc = 8'h87;
            frame = {2'b01, ridx, 32'($urandom), rcrc};
            if ($urandom_range(0, 9) == 0) frame[46] = 1'b0;
            if ($urandom_range(0, 9) == 0) frame[0]  = 1'b0;
            do_cmd($sformatf("rand%0d_idx%0d", k, ridx), frame);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
